bidir_bus_transceiver: RTL and testbench
========================================

BIDIR_BUS_TRANSCEIVER -- requirements
Module: bidir_bus_transceiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the shared bus and both data paths.
REQ-002 The block SHALL have parameter TURN_CYCLES, default 2: released-bus cycles inserted at every direction change; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port dir_tx, input, 1: requested direction; 1 = drive bus, 0 = receive.
REQ-006 The block SHALL have port tx_data, input, WIDTH: outbound word.
REQ-007 The block SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-008 The block SHALL have port tx_ready, output, 1: outbound word accepted this cycle if tx_valid is high.
REQ-009 The block SHALL have port rx_strobe, input, 1: capture the bus this cycle.
REQ-010 The block SHALL have port rx_data, output, WIDTH: last captured bus word.
REQ-011 The block SHALL have port rx_valid, output, 1: one-cycle pulse marking a new rx_data.
REQ-012 The block SHALL have port bus_drv, output, 1: high exactly when the block drives bus.
REQ-013 The block SHALL have port bus, inout, WIDTH: shared tri-state bus.

Function
REQ-014 The FSM SHALL have states RX, TURN and TX; the state register SHALL be 2 bits wide.
- RX: bus is Z.
- TURN: bus is Z.
- TX: bus driven from the internal tx_reg.
REQ-015 In RX with dir_tx=1, the FSM SHALL go to TURN with target TX and counter = TURN_CYCLES-1.
REQ-016 In TX with dir_tx=0, the FSM SHALL go to TURN with target RX and counter = TURN_CYCLES-1.
REQ-017 In TURN, the counter SHALL decrement each cycle; at 0, the FSM SHALL enter the target state next edge, giving exactly TURN_CYCLES cycles of Z.
REQ-018 A dir_tx change during TURN SHALL NOT abort the turnaround; dir_tx SHALL be re-evaluated only after the target state is reached.
REQ-019 tx_ready SHALL equal 1 only in TX.
- Handshake at edge N (tx_valid and tx_ready both high): tx_reg <= tx_data.
- bus shows the new word from edge N onward and holds it until the next handshake.
REQ-020 On entering TX, bus SHALL drive the current tx_reg (the last accepted word, or 0 after reset).
REQ-021 In RX, with rx_strobe high at edge N, rx_data SHALL load the bus value at edge N and rx_valid SHALL be high for exactly the cycle after edge N.
REQ-022 rx_strobe SHALL be ignored in TURN and TX: no rx_valid pulse and rx_data unchanged.
REQ-023 Back-to-back rx_strobe SHALL produce back-to-back rx_valid pulses, one per strobe.
REQ-024 bus_drv SHALL be a registered decode of state == TX.
REQ-025 The bus output enable SHALL be derived from that same register, so bus_drv and the actual drive never differ.

Reset
REQ-026 On rst_n low, asynchronously and immediately, the block SHALL set:
- state = RX, bus = Z, bus_drv = 0
- tx_ready = 0, rx_valid = 0
- rx_data = 0, tx_reg = 0, counter = 0
REQ-027 Reset asserted mid-TX or mid-TURN SHALL release the bus without waiting for a clock edge.
REQ-028 After rst_n rises, the first direction change SHALL still insert TURN_CYCLES cycles.

Configuration
REQ-029 Macro BIDIR_BUS_SYNC_EN, when defined, SHALL insert a 2-flop synchroniser on the inbound bus path.
- Captured value = bus as of edge N-2.
- rx_valid timing unchanged.
- Synchroniser flops reset to 0.
REQ-030 Without BIDIR_BUS_SYNC_EN, the bus SHALL be sampled directly with no synchroniser flops.

Structure
REQ-031 Package bidir_pkg SHALL hold the state encoding (RX=0, TURN=1, TX=2) and TURN_CYCLES' default and maximum.
REQ-032 Sub-module bus_sync (WIDTH-wide 2-flop synchroniser, clk/rst_n) SHALL be instantiated only under BIDIR_BUS_SYNC_EN.

Verification
REQ-033 Reset: rst_n=0 with dir_tx=1 and tx_valid=1 -> bus Z, bus_drv=0, tx_ready=0, rx_data=0.
REQ-034 RX capture: external driver puts 8'hA5 on bus, rx_strobe for 1 cycle -> rx_data=8'hA5 and a single rx_valid pulse on the next cycle; repeat with the macro -> same value, captured 2 cycles earlier.
REQ-035 Turnaround: dir_tx 0->1 with TURN_CYCLES=2 -> exactly 2 cycles of Z, then bus_drv=1, tx_ready=1, bus=tx_reg.
REQ-036 TX: tx_data=8'h3C with tx_valid in TX -> bus=8'h3C after the handshake edge and held; dir_tx->0 -> bus Z for 2 cycles, then RX.
REQ-037 dir_tx toggled 1->0 during TURN toward TX -> TX reached, then a second TURN back to RX; there is never contention with the external driver.
REQ-038 Reset mid-TX driving 8'hFF -> bus Z immediately, within the same cycle.

Source files
------------

// File: rtl/bidir_pkg.sv
// Shared definitions for the bidirectional bus transceiver: FSM state encoding
// and turnaround-length limits.
package bidir_pkg;

    typedef enum logic [1:0] {
        ST_RX   = 2'd0,
        ST_TURN = 2'd1,
        ST_TX   = 2'd2
    } state_e;

    localparam int unsigned TURN_CYCLES_DEF = 2;
    localparam int unsigned TURN_CYCLES_MAX = 15;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/bidir_bus_transceiver_sync.sv
// bus_sync: WIDTH-wide two-flop synchroniser for the inbound bus path.
// Only compiled when BIDIR_BUS_SYNC_EN is defined, the sole build that uses it.
`ifdef BIDIR_BUS_SYNC_EN
module bus_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`endif

// File: rtl/bidir_bus_transceiver.sv
// Half-duplex bus transceiver with a fixed released-bus turnaround on every
// direction change. Define BIDIR_BUS_SYNC_EN to synchronise the inbound bus.
module bidir_bus_transceiver
    import bidir_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_tx,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rx_strobe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             bus_drv,
    inout  wire  [WIDTH-1:0] bus
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_turn
        $error("bidir_bus_transceiver: TURN_CYCLES out of range 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYCLES - 1);

    state_e           state_q, state_d;
    logic             tgt_tx_q, tgt_tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_reg_q, tx_reg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             drv_q, drv_d;
    logic [WIDTH-1:0] rx_sample;

`ifdef BIDIR_BUS_SYNC_EN
    bus_sync #(.WIDTH(WIDTH)) u_bus_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus),
        .q_o   (rx_sample)
    );
`else
    assign rx_sample = bus;
`endif

    always_comb begin
        state_d    = state_q;
        tgt_tx_d   = tgt_tx_q;
        cnt_d      = cnt_q;
        tx_reg_d   = tx_reg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            ST_RX: begin
                if (rx_strobe) begin
                    rx_data_d  = rx_sample;
                    rx_valid_d = 1'b1;
                end
                if (dir_tx) begin
                    state_d  = ST_TURN;
                    tgt_tx_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                end
            end
            // dir_tx is deliberately not looked at here: a turnaround always completes.
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = tgt_tx_q ? ST_TX : ST_RX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TX: begin
                if (tx_valid) begin
                    tx_reg_d = tx_data;
                end
                if (!dir_tx) begin
                    state_d  = ST_TURN;
                    tgt_tx_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                end
            end
            default: state_d = ST_RX;
        endcase

        drv_d = (state_d == ST_TX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RX;
            tgt_tx_q   <= 1'b0;
            cnt_q      <= '0;
            tx_reg_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            drv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_tx_q   <= tgt_tx_d;
            cnt_q      <= cnt_d;
            tx_reg_q   <= tx_reg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            drv_q      <= drv_d;
        end
    end

    // One register gates both the status flag and the drivers, so they cannot disagree.
    assign bus      = drv_q ? tx_reg_q : {WIDTH{1'bz}};
    assign bus_drv  = drv_q;
    assign tx_ready = drv_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_bidir_bus_transceiver.sv
// Self-checking bench for bidir_bus_transceiver: a cycle model of the
// direction/turnaround rules plus directed scenarios with literal expectations.
module tb_bidir_bus_transceiver;

    localparam int unsigned W  = 8;
    localparam int          TC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dir_tx;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         rx_strobe;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         bus_drv;
    wire  [W-1:0] bus;
    logic         ext_en;
    logic [W-1:0] ext_drv;

    assign bus = ext_en ? ext_drv : {W{1'bz}};

    bidir_bus_transceiver #(.WIDTH(W), .TURN_CYCLES(TC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir_tx    (dir_tx),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_strobe (rx_strobe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .bus_drv   (bus_drv),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expd);
        n_checks++;
        if (got !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expd, $time);
        end
    endtask

    // Model: settled direction m_mode (1 = transmitting), turn cycles left m_left.
    int           m_left   = 0;
    logic         m_mode   = 1'b0;
    logic         m_target = 1'b0;
    logic [W-1:0] m_word   = '0;
    logic [W-1:0] m_rxd    = '0;
    logic         m_rxv    = 1'b0;
    logic [W-1:0] h1       = '0;
    logic [W-1:0] h2       = '0;

    initial forever begin
        logic [W-1:0] cur;
        logic [W-1:0] smp;
        logic         in_rx;
        logic         in_tx;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_left = 0; m_mode = 1'b0; m_target = 1'b0;
            m_word = '0; m_rxd = '0; m_rxv = 1'b0; h1 = '0; h2 = '0;
        end else begin
            in_tx = (m_left == 0) && m_mode;
            in_rx = (m_left == 0) && !m_mode;
            cur   = ext_en ? ext_drv : (in_tx ? m_word : '0);
`ifdef BIDIR_BUS_SYNC_EN
            smp = h2;
`else
            smp = cur;
`endif
            h2 = h1;
            h1 = cur;
            m_rxv = in_rx && rx_strobe;
            if (m_rxv) m_rxd = smp;
            if (in_tx && tx_valid) m_word = tx_data;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) m_mode = m_target;
            end else if (dir_tx != m_mode) begin
                m_left   = TC;
                m_target = dir_tx;
            end
        end
    end

    initial forever begin
        logic exp_drv;
        @(negedge clk);
        exp_drv = (m_left == 0) && m_mode;
        check("cmp_bus_drv",  32'(bus_drv),  32'(exp_drv));
        check("cmp_tx_ready", 32'(tx_ready), 32'(exp_drv));
        check("cmp_rx_valid", 32'(rx_valid), 32'(m_rxv));
        check("cmp_rx_data",  32'(rx_data),  32'(m_rxd));
        if (exp_drv) check("cmp_bus_word", 32'(bus), 32'(m_word));
        check("cmp_no_contention", 32'(ext_en && bus_drv), 0);
    end

    task automatic wait_drv(input logic want, output int z);
        z = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_drv == want) return;
            z++;
        end
        z = 99;
    endtask

    initial begin
        int           z;
        int           n;
        logic [5:0]   seq;
        logic [W-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

        rst_n = 1'b0; dir_tx = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        rx_strobe = 1'b0; ext_en = 1'b0; ext_drv = '0;
        repeat (3) @(negedge clk);
        check("rst_bus_drv",  32'(bus_drv),  0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_data",  32'(rx_data),  0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        #1 dir_tx = 1'b0; tx_valid = 1'b0; rst_n = 1'b1;

        // Receive a single word
        @(negedge clk); #1 ext_en = 1'b1; ext_drv = 8'hA5;
        repeat (2) @(negedge clk);
        #1 rx_strobe = 1'b1;
        @(negedge clk);
        check("rx_pulse",      32'(rx_valid), 1);
        check("rx_word",       32'(rx_data),  32'hA5);
        #1 rx_strobe = 1'b0;
        @(negedge clk);
        check("rx_pulse_end",  32'(rx_valid), 0);
        check("rx_word_hold",  32'(rx_data),  32'hA5);

        // Back-to-back strobes
        #1 rx_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_drv = vals[i];
            @(negedge clk);
            check("b2b_pulse", 32'(rx_valid), 1);
            #1;
        end
        rx_strobe = 1'b0; ext_en = 1'b0; ext_drv = '0;
        @(negedge clk);
        check("b2b_end", 32'(rx_valid), 0);

        // RX -> TX turnaround
        #1 dir_tx = 1'b1;
        wait_drv(1'b1, z);
        check("turn_rx_tx_cycles", 32'(z),        2);
        check("tx_ready_in_tx",    32'(tx_ready), 1);
        check("tx_reg_after_rst",  32'(bus),      0);

        // Transmit handshake and hold
        #1 tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        check("tx_word", 32'(bus), 32'h3C);
        #1 tx_valid = 1'b0; tx_data = 8'h77;
        repeat (2) @(negedge clk);
        check("tx_word_hold", 32'(bus), 32'h3C);

        // TX -> RX: strobe is ignored until the turnaround is over
        #1 dir_tx = 1'b0;
        @(negedge clk);
        check("tx_release", 32'(bus_drv), 0);
        #1 ext_en = 1'b1; ext_drv = 8'h5A; rx_strobe = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rx_valid) break;
        end
        check("rx_resume_cycles", 32'(n),       3);
        check("rx_resume_word",   32'(rx_data), 32'h5A);

        // Reversal during TURN: TX is still reached, then a second turnaround
        #1 rx_strobe = 1'b0; ext_en = 1'b0; dir_tx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq[i] = bus_drv;
            check("turn_strobe_ignored", 32'(rx_valid), 0);
            if (i == 2) check("reenter_tx_word", 32'(bus), 32'h3C);
            if (i == 0) begin #1 dir_tx = 1'b0; rx_strobe = 1'b1; end
            if (i == 3) begin #1 rx_strobe = 1'b0; end
        end
        check("reverse_drv_seq", 32'(seq),     32'b000100);
        check("reverse_rx_data", 32'(rx_data), 32'h5A);

        // Reset mid-TX releases the bus without a clock edge
        #1 dir_tx = 1'b1;
        wait_drv(1'b1, z);
        check("turn_again_cycles", 32'(z), 2);
        #1 tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        check("tx_ff", 32'(bus), 32'hFF);
        #1 tx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus_drv",  32'(bus_drv),  0);
        check("async_rst_tx_ready", 32'(tx_ready), 0);
        check("async_rst_rx_data",  32'(rx_data),  0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_drv(1'b1, z);
        check("post_rst_turn_cycles", 32'(z),   2);
        check("post_rst_tx_reg",      32'(bus), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
